// File: rtl/seg7_result_display.sv
// seg7_result_display: converts the 8-bit result to BCD by sequential double-dabble
// and scans it onto a 3-digit 7-segment display with leading-zero blanking.
module seg7_result_display #(
    parameter int REFRESH_DIV    = 1000,
    parameter bit SEG_ACTIVE_LOW = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        display_enable,
    input  logic [7:0]  display_value,
    output logic        busy,
    output logic [11:0] bcd,
    output logic [2:0]  an,
    output logic [6:0]  seg
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CONV = 2'd1;
    localparam logic [1:0] LOAD = 2'd2;
    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    logic [1:0]    state;
    logic          valid;
    logic [7:0]    shown_raw;
    logic [19:0]   sr;
    logic [19:0]   sr_adj;
    logic [2:0]    iter;
    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [3:0]    nib;
    logic          lit;
    logic [2:0]    an_on;
    logic [6:0]    seg_on;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    assign sr_adj = {add3(sr[19:16]), add3(sr[15:12]), add3(sr[11:8]), sr[7:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            bcd       <= 12'h000;
            valid     <= 1'b0;
            shown_raw <= 8'h00;
            sr        <= 20'h0;
            iter      <= 3'd0;
        end else begin
            case (state)
                IDLE: if (display_enable && (!valid || display_value != shown_raw)) begin
                    shown_raw <= display_value;
                    sr        <= {12'h000, display_value};
                    iter      <= 3'd0;
                    busy      <= 1'b1;
                    state     <= CONV;
                end
                CONV: begin
                    sr    <= {sr_adj[18:0], 1'b0};
                    iter  <= iter + 3'd1;
                    state <= (iter == 3'd7) ? LOAD : CONV;
                end
                LOAD: begin
                    bcd   <= sr[19:8];
                    valid <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Scan timing free-runs so digit brightness never depends on conversion activity.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            idx <= 2'd0;
        end else if (cnt == CW'(REFRESH_DIV - 1)) begin
            cnt <= '0;
            idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        nib    = (idx == 2'd0) ? bcd[3:0] : (idx == 2'd1) ? bcd[7:4] : bcd[11:8];
        lit    = display_enable && valid && (idx == 2'd0 || (idx == 2'd1 && bcd[11:4] != 8'h00) ||
                 (idx == 2'd2 && bcd[11:8] != 4'h0));
        an_on  = lit ? (3'b001 << idx) : 3'b000;
        seg_on = lit ? seg_of(nib) : 7'h00;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an  <= {3{SEG_ACTIVE_LOW}};
            seg <= {7{SEG_ACTIVE_LOW}};
        end else begin
            an  <= SEG_ACTIVE_LOW ? ~an_on : an_on;
            seg <= SEG_ACTIVE_LOW ? ~seg_on : seg_on;
        end
    end

    bcd_digits_ok: assert property (@(posedge clk) disable iff (!rst)
        bcd[3:0] <= 4'd9 && bcd[7:4] <= 4'd9 && bcd[11:8] <= 4'd9);
endmodule

// File: tb/tb_seg7_result_display.sv
// tb_seg7_result_display: scoreboard bench; expected BCD is queued when a value is
// driven and compared when busy falls, scan output checked against a segment table.
module tb_seg7_result_display;
    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        display_enable = 1'b0;
    logic [7:0]  display_value = 8'h00;
    logic        busy;
    logic [11:0] bcd;
    logic [2:0]  an;
    logic [6:0]  seg;

    seg7_result_display #(.REFRESH_DIV(DIV), .SEG_ACTIVE_LOW(1)) dut (
        .clk(clk), .rst(rst), .display_enable(display_enable), .display_value(display_value),
        .busy(busy), .bcd(bcd), .an(an), .seg(seg)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;
    logic [11:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [6:0] enc(input int d);
        case (d)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    logic busy_q = 1'b0;
    int   rise_cyc = 0;
    always @(negedge clk) begin
        if (!rst) busy_q = 1'b0;
        else begin
            if (busy && !busy_q) rise_cyc = cyc;
            if (!busy && busy_q) begin
                if (exp_q.size() == 0) check("unexpected_conv", 32'd1, 32'd0);
                else begin
                    check("bcd", bcd, exp_q.pop_front());
                    check("latency", cyc - rise_cyc, 9);
                end
            end
            busy_q = busy;
        end
    end

    task automatic drive(input int v);
        display_value  = 8'(v);
        display_enable = 1'b1;
        exp_q.push_back(to_bcd(v));
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain", exp_q.size(), 0);
    endtask

    task automatic wait_rise();
        @(negedge clk);
        for (int i = 0; i < 20 && !busy; i++) @(negedge clk);
        check("busy_rise", busy, 1'b1);
    endtask

    task automatic show(input int v);
        int h = v / 100;
        int t = (v / 10) % 10;
        int u = v % 10;
        int c0 = 0, c1 = 0, c2 = 0;
        logic [6:0] e;
        repeat (3 * DIV) begin
            @(negedge clk);
            case (an)
                3'b110: begin c0++; e = ~enc(u); check("seg_units", seg, e); end
                3'b101: begin c1++; e = ~enc(t); check("seg_tens", seg, e); end
                3'b011: begin c2++; e = ~enc(h); check("seg_hundreds", seg, e); end
                3'b111: check("seg_blank", seg, 7'h7F);
                default: check("an_onehot", an, 3'b110);
            endcase
        end
        check("slots_units", c0, DIV);
        check("slots_tens", c1, (h != 0 || t != 0) ? DIV : 0);
        check("slots_hundreds", c2, (h != 0) ? DIV : 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_an", an, 3'b111);
        check("rst_seg", seg, 7'h7F);
        check("rst_bcd", bcd, 12'h000);
        check("rst_busy", busy, 1'b0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_blank_an", an, 3'b111);
        drive(240); drain(); @(negedge clk); show(240);
        drive(255); drain(); @(negedge clk); show(255);
        drive(0);   drain(); @(negedge clk); show(0);
        drive(7);   drain(); @(negedge clk); show(7);
        drive(10);  drain(); @(negedge clk); show(10);
        drive(100);
        wait_rise();
        repeat (2) @(negedge clk);
        drive(42);
        check("hold_prev_bcd", bcd, 12'h010);
        for (int i = 0; i < 20 && busy; i++) @(negedge clk);
        @(negedge clk);
        check("recapture", busy, 1'b1);
        drain(); @(negedge clk); show(42);
        drive(99);
        wait_rise();
        display_enable = 1'b0;
        drain();
        repeat (2) @(negedge clk);
        check("disabled_an", an, 3'b111);
        check("disabled_seg", seg, 7'h7F);
        display_enable = 1'b1;
        repeat (3) @(negedge clk);
        check("no_recapture", busy, 1'b0);
        show(99);
        drive(123);
        wait_rise();
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        exp_q.delete();
        #1;
        check("arst_busy", busy, 1'b0);
        check("arst_bcd", bcd, 12'h000);
        check("arst_an", an, 3'b111);
        check("arst_seg", seg, 7'h7F);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        exp_q.push_back(to_bcd(123));
        drain(); @(negedge clk); show(123);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
